// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, XLEN-cycle latency for every op including the special cases.
module muldiv_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN) + 1;
   localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            r_state;
   logic [CW-1:0]     r_count;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_hi;
   logic [XLEN-1:0]   r_lo;
   logic [XLEN-1:0]   r_m;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_spec;
   logic [XLEN-1:0]   r_spec_val;
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;

   logic              w_is_div;
   logic              w_a_sgn;
   logic              w_b_sgn;
   logic              w_neg_a;
   logic              w_neg_b;
   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic              w_div0;
   logic              w_ovf;
   logic [XLEN-1:0]   w_spec_val;

   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shift;
   logic [XLEN:0]     w_diff;
   logic [XLEN-1:0]   w_hi_nx;
   logic [XLEN-1:0]   w_lo_nx;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_final;

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;

   // Operand decode at accept: signedness, magnitudes and special-case results
   always_comb begin
      w_is_div   = op[2];
      w_a_sgn    = ~(op[0] & (op[1] | op[2]));
      w_b_sgn    = op[2] ? ~op[0] : ~op[1];
      w_neg_a    = w_a_sgn & in_a[XLEN-1];
      w_neg_b    = w_b_sgn & in_b[XLEN-1];
      w_mag_a    = w_neg_a ? (XLEN'(0) - in_a) : in_a;
      w_mag_b    = w_neg_b ? (XLEN'(0) - in_b) : in_b;
      w_div0     = w_is_div && (in_b == '0);
      w_ovf      = w_is_div && !op[0] && (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
      w_spec_val = '0;
      if (w_div0)
         w_spec_val = op[1] ? in_a : '1;
      else if (w_ovf)
         w_spec_val = op[1] ? '0 : in_a;
   end

   // One iteration of the datapath plus sign fix-up of the final value
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      w_shift = {r_hi, r_lo[XLEN-1]};
      w_diff  = w_shift - {1'b0, r_m};
      if (r_op[2]) begin
         if (!w_diff[XLEN]) begin
            w_hi_nx = w_diff[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
         end else begin
            w_hi_nx = w_shift[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         w_hi_nx = w_sum[XLEN:1];
         w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
      end
      w_prod   = {w_hi_nx, w_lo_nx};
      w_prod_s = r_neg_q ? ((2*XLEN)'(0) - w_prod) : w_prod;
      w_quo    = r_neg_q ? (XLEN'(0) - w_lo_nx) : w_lo_nx;
      w_rem    = r_neg_r ? (XLEN'(0) - w_hi_nx) : w_hi_nx;
      if (r_spec)
         w_final = r_spec_val;
      else begin
         case (r_op)
            3'b000:                 w_final = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
         endcase
      end
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_count    <= '0;
         r_op       <= '0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_m        <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_spec     <= 1'b0;
         r_spec_val <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (start && !flush) begin
                  r_state    <= S_CALC;
                  r_busy     <= 1'b1;
                  r_count    <= '0;
                  r_op       <= op;
                  r_hi       <= '0;
                  r_lo       <= w_is_div ? w_mag_a : w_mag_b;
                  r_m        <= w_is_div ? w_mag_b : w_mag_a;
                  r_neg_q    <= w_neg_a ^ w_neg_b;
                  r_neg_r    <= w_neg_a;
                  r_spec     <= w_div0 | w_ovf;
                  r_spec_val <= w_spec_val;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            S_CALC: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_hi    <= w_hi_nx;
                  r_lo    <= w_lo_nx;
                  r_count <= r_count + CW'(1);
                  if (r_count == LAST) begin
                     r_state  <= S_DONE;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                     r_result <= w_final;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  op;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
      .in_a(in_a), .in_b(in_b), .busy(busy), .done(done), .result(result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RISC-V M semantics computed directly with wide integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, p;
      logic [63:0] up;
      int          ia, ib;
      logic        ovf;
      logic [31:0] r;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ia  = $signed(a);
      ib  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = sa * sb; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'({32'h0, b}); r = p[63:32]; end
         3'd3: begin up = {32'h0, a} * {32'h0, b}; r = up[63:32]; end
         3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      op    = f;
      in_a  = a;
      in_b  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int n0, output int n);
      n = n0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
   endtask

   task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int n;
      issue(f, a, b);
      wait_done(0, n);
      chk({tag, "_lat"}, 32'(n), 32'd32);
      chk(tag, result, ref_model(f, a, b));
   endtask

   initial begin
      int          n;
      int          bc;
      int          dc;
      logic [31:0] held;
      logic [2:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] pick [5];

      rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; in_a = '0; in_b = '0;
      tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'h0);
      rst = 1'b0;
      tick();

      // MUL with latency and busy-width checks
      issue(3'd0, 32'd7, 32'hFFFF_FFFD);
      bc = busy ? 1 : 0;
      n  = 0;
      while (!done && n < 40) begin
         tick();
         n++;
         if (busy) bc++;
      end
      chk("mul_lat", 32'(n), 32'd32);
      chk("mul_busy_cycles", 32'(bc), 32'd32);
      chk("mul_7x-3", result, 32'hFFFF_FFEB);
      tick();
      chk("done_one_cycle", 32'(done), 32'd0);

      run("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("mulh_const", result, 32'h0000_0000);
      run("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("mulhu_const", result, 32'h7FFF_FFFF);
      run("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("mulhsu_const", result, 32'h8000_0000);

      run("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      chk("div_-7_2_const", result, 32'hFFFF_FFFD);
      run("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
      chk("rem_-7_2_const", result, 32'hFFFF_FFFF);
      run("divu_100_7", 3'd5, 32'd100, 32'd7);
      chk("divu_100_7_const", result, 32'd14);
      run("remu_100_7", 3'd7, 32'd100, 32'd7);
      chk("remu_100_7_const", result, 32'd2);

      run("div_by0", 3'd4, 32'h1234_5678, 32'd0);
      chk("div_by0_const", result, 32'hFFFF_FFFF);
      run("remu_by0", 3'd7, 32'd5, 32'd0);
      chk("remu_by0_const", result, 32'd5);
      run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_const", result, 32'h8000_0000);
      run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("rem_ovf_const", result, 32'h0);

      // start while busy is ignored and not queued
      issue(3'd0, 32'd6, 32'd7);
      repeat (9) tick();
      op = 3'd5; in_a = 32'd100; in_b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(10, n);
      chk("midstart_lat", 32'(n), 32'd32);
      chk("midstart_result", result, 32'd42);
      tick();
      chk("midstart_no_queue", 32'(busy), 32'd0);

      // flush at cycle 10, together with a start that must be dropped
      held = result;
      issue(3'd4, 32'd1000, 32'd3);
      repeat (9) tick();
      flush = 1'b1; start = 1'b1; op = 3'd0; in_a = 32'd2; in_b = 32'd2;
      tick();
      flush = 1'b0; start = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      dc = 0;
      repeat (40) begin
         if (done) dc++;
         tick();
      end
      chk("flush_no_done", 32'(dc), 32'd0);
      chk("flush_result_kept", result, held);

      // reset mid-operation
      issue(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", result, 32'h0);
      tick();

      // back-to-back issue in the DONE cycle
      issue(3'd7, 32'd12345, 32'd100);
      wait_done(0, n);
      chk("b2b_first", result, 32'd45);
      op = 3'd0; in_a = 32'd1000; in_b = 32'd1000; start = 1'b1;
      tick();
      start = 1'b0;
      chk("b2b_accept_busy", 32'(busy), 32'd1);
      wait_done(0, n);
      chk("b2b_lat", 32'(n), 32'd32);
      chk("b2b_second", result, 32'd1000000);
      tick();

      // random sweep with a bias toward corner operand values
      pick[0] = 32'h0; pick[1] = 32'h1; pick[2] = 32'hFFFF_FFFF;
      pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF;
      for (int i = 0; i < 60; i++) begin
         rf = 3'($urandom_range(0, 7));
         ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 30);
         run($sformatf("rnd%0d_op%0d_a%h_b%h", i, rf, ra, rb), rf, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
